// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer.
// Issues in-order memory reads from a running fetch PC, buffers each response
// together with its PC, and hands instructions to the consumer through a
// valid/ready head port. A redirect flushes the buffer and restarts fetch;
// responses still in flight from before the redirect are dropped by a counter.
// Optional build macro: FETCH_QUEUE_PERF_EN adds stall/flush performance counters.
module fetch_queue #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [AWIDTH-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [DWIDTH-1:0] rsp_data,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [AWIDTH-1:0]  fetch_pc_q;
  logic [AWIDTH-1:0]  rsp_pc_q;     // PC of the next response that will be kept
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;      // buffered entries
  logic [CNT_W-1:0]   out_q, out_d; // accepted requests awaiting a response (incl. dropped)
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [AWIDTH-1:0]  mem_pc   [DEPTH];
  logic [DWIDTH-1:0]  mem_data [DEPTH];

  logic [CNT_W:0] reserved;
  logic           can_issue;
  logic           req_fire;
  logic           rsp_fire;
  logic           drop_rsp;
  logic           push;
  logic           pop;

  // Every outstanding request owns a buffer slot, so a response can always be
  // written even when the consumer is stalled.
  assign reserved  = {1'b0, count_q} + {1'b0, out_q};
  assign can_issue = reserved < DEPTH_W;

  assign req_fire = req_valid && req_ready;
  // A response with nothing outstanding belongs to a request lost to reset.
  assign rsp_fire = rsp_valid && (out_q != '0);
  assign drop_rsp = rsp_fire && (drop_q != '0);
  assign push     = rsp_fire && !drop_rsp && !redirect_valid;
  assign pop      = insn_valid && insn_ready && !redirect_valid;

  assign req_addr   = fetch_pc_q;
  assign insn_valid = (count_q != '0);
  assign pc_o       = mem_pc[head_q];
  assign insn_o     = mem_data[head_q];

  // Control FSM: request issue, outstanding/drop bookkeeping, RUN/DRAIN.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    req_valid = 1'b0;
    out_d     = out_q;
    drop_d    = drop_q;

    if (redirect_valid) begin
      // Everything still in flight, minus a response landing this cycle
      // (which is discarded too), must be dropped when it returns.
      out_d  = out_q - CNT_W'(rsp_fire);
      drop_d = out_d;
    end else begin
      // In DRAIN the dropped requests are still counted in out_q, so the same
      // capacity test leaves room for them.
      req_valid = rst && can_issue;
      out_d     = out_q + CNT_W'(req_valid && req_ready) - CNT_W'(rsp_fire);
      drop_d    = drop_q - CNT_W'(drop_rsp);
    end

    unique case (state_q)
      RUN:     if (drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State, pointers, fetch PC and buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state_q    <= RUN;
      fetch_pc_q <= BASEADDR;
      rsp_pc_q   <= BASEADDR;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      // NOTE: the buffer storage is reset so the head port shows BASEADDR/0
      // during reset; it is small enough that flops are the natural choice.
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= BASEADDR;
        mem_data[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        rsp_pc_q   <= redirect_pc;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + AWIDTH'(4);
        if (push) begin
          mem_pc[tail_q]   <= rsp_pc_q;
          mem_data[tail_q] <= rsp_data;
          tail_q           <= tail_q + PTR_W'(1);
          rsp_pc_q         <= rsp_pc_q + AWIDTH'(4);
        end
        if (pop) head_q <= head_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating counters: consumer starved cycles and redirects seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_o <= '0;
      perf_flush_o <= '0;
    end else begin
      if (insn_ready && !insn_valid && (perf_stall_o != '1))
        perf_stall_o <= perf_stall_o + 32'd1;
      if (redirect_valid && (perf_flush_o != '1))
        perf_flush_o <= perf_flush_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a 1-cycle in-order
// memory model. Inputs change on the falling edge; outputs are checked there.
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] pc_o;
  logic [31:0] insn_o;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .pc_o           (pc_o),
    .insn_o         (insn_o)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_req   = 0;
  int          n_hold  = 0;
  logic [31:0] pend[$];
  logic [31:0] exp_req;
  logic [31:0] exp_pop;
  logic        mem_hold   = 1'b0;
  logic        stall_pend = 1'b0;
  logic [31:0] stall_addr = '0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: check request/pop traffic of this cycle, then after the edge
  // present the next in-order memory response.
  task automatic tick();
    #1;
    if (req_valid && req_ready) begin
      check("req_seq", req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      pend.push_back(req_addr);
      n_req++;
    end
    if (stall_pend && req_valid) begin
      check("req_hold", req_addr, stall_addr);
      n_hold++;
    end
    stall_pend = req_valid && !req_ready;
    stall_addr = req_addr;
    if (rst && !redirect_valid && insn_valid && insn_ready) begin
      check("pop_pc", pc_o, exp_pop);
      check("pop_insn", insn_o, img(exp_pop));
      exp_pop = exp_pop + 32'd4;
    end
    if (!rst) pend.delete();
    @(posedge clk);
    @(negedge clk);
    if (!mem_hold && pend.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = img(pend.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  endtask

  task automatic wait_insn(input string tag);
    int n = 0;
    while (!insn_valid && n < 30) begin
      tick();
      n++;
    end
    check(tag, insn_valid, 1);
  endtask

  initial begin
    rst            = 1'b0;
    req_ready      = 1'b1;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    insn_ready     = 1'b1;
    exp_req        = BASE;
    exp_pop        = BASE;

    // Reset values
    @(negedge clk);
    tick();
    check("rst_req_valid", req_valid, 0);
    check("rst_insn_valid", insn_valid, 0);
    check("rst_pc_o", pc_o, BASE);
    check("rst_insn_o", insn_o, 0);
    check("rst_req_addr", req_addr, BASE);

    // Streaming with always-ready memory and consumer
    rst = 1'b1;
    tick();
    check("first_latency", insn_valid, 0);
    check("addr_after_1", req_addr, 32'h0100_0004);
    tick();
    check("s0_valid", insn_valid, 1);
    check("s0_pc", pc_o, 32'h0100_0000);
    check("s0_insn", insn_o, img(32'h0100_0000));
    tick();
    check("s1_pc", pc_o, 32'h0100_0004);
    tick();
    check("s2_pc", pc_o, 32'h0100_0008);
    tick();
    check("s3_pc", pc_o, 32'h0100_000C);
    check("s3_insn", insn_o, img(32'h0100_000C));

    // Reset mid-stream for one cycle
    rst = 1'b0;
    tick();
    check("mid_rst_req_valid", req_valid, 0);
    check("mid_rst_insn_valid", insn_valid, 0);
    check("mid_rst_pc_o", pc_o, BASE);
    check("mid_rst_insn_o", insn_o, 0);
    check("mid_rst_req_addr", req_addr, BASE);

    // Release with a stale response on the bus; consumer stalled for 10 cycles
    rst        = 1'b1;
    insn_ready = 1'b0;
    exp_req    = BASE;
    exp_pop    = BASE;
    n_req      = 0;
    rsp_valid  = 1'b1;
    rsp_data   = 32'hBAD0_BAD0;
    tick();
    check("stale_ignored", insn_valid, 0);
    tick();
    check("restart_valid", insn_valid, 1);
    check("restart_pc", pc_o, BASE);
    for (int i = 0; i < 8; i++) tick();
    check("full_req_count", n_req, 4);
    check("full_req_valid", req_valid, 0);
    check("full_head_valid", insn_valid, 1);
    check("full_head_pc", pc_o, BASE);
    check("full_head_insn", insn_o, img(BASE));

    // Drain from full while refilling
    insn_ready = 1'b1;
    tick();
    check("drain_pc0", pc_o, 32'h0100_0004);
    tick();
    check("drain_pc1", pc_o, 32'h0100_0008);
    tick();
    check("drain_pc2", pc_o, 32'h0100_000C);
    tick();
    check("drain_pc3", pc_o, 32'h0100_0010);

    // Request back-pressure toggling
    for (int i = 0; i < 8; i++) begin
      req_ready = (i % 2 == 1);
      tick();
    end
    req_ready = 1'b1;
    check("hold_seen", n_hold > 0, 1);

    // Redirect with 3 requests outstanding
    mem_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pend.size() == 3) break;
    end
    check("outstanding_3", pend.size() == 3, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0100;
    mem_hold       = 1'b0;
    rsp_valid      = 1'b1;
    rsp_data       = img(pend.pop_front());
    tick();
    redirect_valid = 1'b0;
    exp_req        = 32'h0100_0100;
    exp_pop        = 32'h0100_0100;
    check("redir_flush", insn_valid, 0);
    check("redir_addr", req_addr, 32'h0100_0100);
    wait_insn("redir_wait");
    check("redir_pc", pc_o, 32'h0100_0100);
    check("redir_insn", insn_o, img(32'h0100_0100));

    // Back-to-back redirects, last one wraps the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0200_0000;
    tick();
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    exp_req        = 32'hFFFF_FFFC;
    exp_pop        = 32'hFFFF_FFFC;
    check("b2b_flush", insn_valid, 0);
    check("b2b_addr", req_addr, 32'hFFFF_FFFC);
    wait_insn("wrap_wait0");
    check("wrap_pc0", pc_o, 32'hFFFF_FFFC);
    tick();
    wait_insn("wrap_wait1");
    check("wrap_pc1", pc_o, 32'h0000_0000);
    check("wrap_insn1", insn_o, img(32'h0000_0000));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: instruction width in bits.
REQ-002 SHALL have parameter AWIDTH, default 32: address width in bits.
REQ-003 SHALL have parameter BASEADDR, default 32'h01000000: reset fetch address.
REQ-004 SHALL have parameter DEPTH, default 4: instruction buffer entries; power of 2, 2..16.
REQ-005 SHALL have port clk  in  1: clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1: reset; synchronous, active-low.
REQ-007 SHALL have port req_valid  out  1: memory read request valid.
REQ-008 SHALL have port req_ready  in  1: memory accepts request.
REQ-009 SHALL have port req_addr  out  AWIDTH: request address.
REQ-010 SHALL have port rsp_valid  in  1: read data valid; responses return in request order.
REQ-011 SHALL have port rsp_data  in  DWIDTH: read data.
REQ-012 SHALL have port redirect_valid  in  1: flush and restart fetch.
REQ-013 SHALL have port redirect_pc  in  AWIDTH: restart address.
REQ-014 SHALL have port insn_valid  out  1: buffer head valid.
REQ-015 SHALL have port insn_ready  in  1: consumer takes head.
REQ-016 SHALL have port pc_o  out  AWIDTH: PC of head instruction.
REQ-017 SHALL have port insn_o  out  DWIDTH: head instruction.

Function
REQ-018 SHALL issue a request when occupancy + outstanding < DEPTH and no redirect is present; handshake completes when req_valid and req_ready are both high.
REQ-019 SHALL hold req_addr stable while req_valid is high and req_ready is low; SHALL advance fetch PC by 4 per accepted request, wrapping modulo 2^AWIDTH.
REQ-020 SHALL write each accepted response with its PC into the buffer tail in the same edge; insn_valid SHALL rise the cycle after the first response (1-cycle latency).
REQ-021 SHALL pop the head when insn_valid and insn_ready are both high; pc_o/insn_o SHALL hold while insn_valid is high and insn_ready is low.
REQ-022 SHALL support simultaneous push and pop on a full or empty buffer without loss or duplication.
REQ-023 SHALL never overflow: outstanding + occupancy <= DEPTH at all times.
REQ-024 On redirect_valid: buffer emptied, insn_valid low the next cycle, fetch PC := redirect_pc, req_valid low that cycle.
REQ-025 Responses to requests accepted before a redirect SHALL be discarded via a drop counter loaded with the outstanding count; a response arriving in the redirect cycle SHALL also be discarded.
REQ-026 Redirect takes priority over pop, push, and request in the same cycle.
REQ-027 Back-to-back redirects SHALL each restart from the latest redirect_pc.
REQ-028 Control SHALL be a two-state machine: RUN (issuing), DRAIN (drop counter nonzero; issue allowed only if capacity remains after counting dropped entries); DRAIN -> RUN when drop counter reaches 0.

Reset
REQ-029 While rst is low at a clock edge: fetch PC = BASEADDR, buffer empty, outstanding = 0, drop counter = 0, state = RUN.
REQ-030 During reset req_valid = 0, insn_valid = 0, pc_o = BASEADDR, insn_o = 0, req_addr = BASEADDR.
REQ-031 Reset mid-operation SHALL abandon all buffered and outstanding data; responses after reset release SHALL be ignored until a new request is accepted.

Configuration
REQ-032 With FETCH_QUEUE_PERF_EN defined: output perf_stall_o (32 bit) counts cycles with insn_ready high and insn_valid low, output perf_flush_o (32 bit) counts redirects; both saturate at all-ones and clear on reset.
REQ-033 Without FETCH_QUEUE_PERF_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset, memory always ready, 1-cycle response, insn_ready=1 -> pc_o sequence 01000000, 01000004, 01000008, 0100000C with insn_o matching memory image.
REQ-035 insn_ready=0 for 10 cycles -> exactly DEPTH requests issued, req_valid low, head held at 01000000.
REQ-036 req_ready toggling 1/0 -> req_addr stable during stall, no address skipped or repeated.
REQ-037 Redirect to 01000100 with 3 outstanding -> 3 responses dropped, next insn_valid shows pc_o=01000100.
REQ-038 Redirect_pc=FFFFFFFC (AWIDTH=32) -> following pc_o values FFFFFFFC, 00000000.
REQ-039 rst low mid-stream for 1 cycle -> outputs at reset values, fetch restarts at 01000000.
